ifu_prefetch: RTL

Parametrised successor to the single-slot instruction fetch stage. It sits between the ICache and the IDU and decouples cache hits from decode stalls with a DEPTH-entry fetch queue. It supports redirects from the pipeline (jump) and the CSR unit (trap/mret), including redirects that arrive while a cache miss is in flight. It predicts the next fetch PC with either a 2-bit-counter BHT or the static backward-taken rule, chosen at compile time.

---
 rtl/ifu_prefetch_if.sv | 32 +++
 rtl/ifu_prefetch.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch_if.sv
// Fetch-stage bus bundle: ICache request/response, redirects, BHT update, IDU queue head.
interface ifu_prefetch_if;
  logic [31:0] ic_addr;
  logic        ic_hit;
  logic [31:0] ic_inst;
  logic        jump_flush;
  logic [31:0] jump_dnpc;
  logic        cs_flush;
  logic [31:0] cs_dnpc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_pred_taken;

  // Fetch unit side
  modport master (
    output ic_addr, out_valid, out_pc, out_inst, out_pred_taken,
    input  ic_hit, ic_inst, jump_flush, jump_dnpc, cs_flush, cs_dnpc,
           upd_valid, upd_pc, upd_taken, out_ready
  );

  // Cache / pipeline / decoder side
  modport slave (
    input  ic_addr, out_valid, out_pc, out_inst, out_pred_taken,
    output ic_hit, ic_inst, jump_flush, jump_dnpc, cs_flush, cs_dnpc,
           upd_valid, upd_pc, upd_taken, out_ready
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch stage: DEPTH-entry fetch queue between ICache and IDU,
// redirect handling across outstanding misses, and next-PC prediction.
// Optional feature macro IFU_BHT_EN: 2-bit-counter BHT for conditional branches;
// without it, conditional branches use static backward-taken prediction.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned BHT_ENTRIES = 64
) (
  input logic            clock,
  input logic            reset,
  ifu_prefetch_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Elaboration-time parameter sanity
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      BHT_ENTRIES < 1 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bad_param
    $error("ifu_prefetch: DEPTH and BHT_ENTRIES must be powers of two, DEPTH >= 2");
  end

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   saved_pc_q, saved_pc_d;
  logic          flush_pend_q, flush_pend_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   q_pc_q   [DEPTH];
  logic [31:0]   q_pc_d   [DEPTH];
  logic [31:0]   q_inst_q [DEPTH];
  logic [31:0]   q_inst_d [DEPTH];
  logic          q_pred_q [DEPTH];
  logic          q_pred_d [DEPTH];

  logic [4:0]  opcode;
  logic        is_jal, is_br, br_pred, pred;
  logic [31:0] imm_j, imm_b, incr;
  logic        flush_any;
  logic [31:0] dnpc;
  logic        pop, push;

`ifdef IFU_BHT_EN
  localparam int unsigned BW = $clog2(BHT_ENTRIES);
  logic [1:0]    bht_q [BHT_ENTRIES];
  logic [1:0]    bht_d [BHT_ENTRIES];
  logic [BW-1:0] upd_idx;

  // Counter update; lookups see the registered (pre-update) value
  always_comb begin
    bht_d   = bht_q;
    upd_idx = bus.upd_pc[BW+1:2];
    if (bus.upd_valid) begin
      if (bus.upd_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
    end
  end

  // BHT counters, weakly not-taken at reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end

  assign br_pred = bht_q[fetch_pc_q[BW+1:2]][1];
`else
  assign br_pred = bus.ic_inst[31];
`endif

  // Predecode of the returned instruction and next-PC increment
  always_comb begin
    opcode = bus.ic_inst[6:2];
    is_jal = (opcode == 5'b11011);
    is_br  = (opcode == 5'b11000);
    imm_j  = {{12{bus.ic_inst[31]}}, bus.ic_inst[19:12], bus.ic_inst[20],
              bus.ic_inst[30:21], 1'b0};
    imm_b  = {{20{bus.ic_inst[31]}}, bus.ic_inst[7], bus.ic_inst[30:25],
              bus.ic_inst[11:8], 1'b0};
    pred   = is_jal | (is_br & br_pred);
    if (is_jal)                incr = imm_j;
    else if (is_br && br_pred) incr = imm_b;
    else                       incr = 32'd4;
  end

  assign flush_any = bus.cs_flush | bus.jump_flush;
  assign dnpc      = bus.cs_flush ? bus.cs_dnpc : bus.jump_dnpc;
  assign pop       = bus.out_valid & bus.out_ready;
  assign push      = bus.ic_hit & ~flush_any & ~flush_pend_q &
                     ((count_q < CW'(DEPTH)) | pop);

  // Fetch PC, redirect tracking and queue bookkeeping
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    saved_pc_d   = saved_pc_q;
    flush_pend_d = flush_pend_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    q_pc_d       = q_pc_q;
    q_inst_d     = q_inst_q;
    q_pred_d     = q_pred_q;

    if (flush_any) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (bus.ic_hit) begin
        fetch_pc_d   = dnpc;
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
        saved_pc_d   = dnpc;
      end
    end else begin
      // Hit returning for a superseded address is dropped
      if (flush_pend_q && bus.ic_hit) begin
        fetch_pc_d   = saved_pc_q;
        flush_pend_d = 1'b0;
      end else if (push) begin
        fetch_pc_d = fetch_pc_q + incr;
      end

      if (push) begin
        q_pc_d[wr_ptr_q]   = fetch_pc_q;
        q_inst_d[wr_ptr_q] = bus.ic_inst;
        q_pred_d[wr_ptr_q] = pred;
        wr_ptr_d           = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      saved_pc_q   <= '0;
      flush_pend_q <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc_q[i]   <= '0;
        q_inst_q[i] <= '0;
        q_pred_q[i] <= 1'b0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      saved_pc_q   <= saved_pc_d;
      flush_pend_q <= flush_pend_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      q_pc_q       <= q_pc_d;
      q_inst_q     <= q_inst_d;
      q_pred_q     <= q_pred_d;
    end
  end

  assign bus.ic_addr        = fetch_pc_q;
  assign bus.out_valid      = (count_q != '0) & ~flush_any;
  assign bus.out_pc         = q_pc_q[rd_ptr_q];
  assign bus.out_inst       = q_inst_q[rd_ptr_q];
  assign bus.out_pred_taken = q_pred_q[rd_ptr_q];

endmodule
